// File: rtl/md_pkg.sv
// md_pkg -- shared definitions for the HI/LO multiply/divide unit.
//   * md_op encodings (3-bit), default mult/div latencies, hilo_sel values.
//   * Sequencer state type and small op-decode helpers.
// Optional feature macro: MD_MADD_EN (md_op 7 = signed multiply-accumulate).
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_MADD  = 3'd7;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the unit for several cycles and commit to HI/LO at the end.
  function automatic logic md_is_start(input logic [2:0] op);
    logic start;
    start = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MD_MADD_EN
    start = start || (op == MD_MADD);
`endif
    return start;
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith -- combinational 64-bit result generator for the HI/LO unit.
// Ports:
//   op     [2:0]  in   operation (md_pkg encoding)
//   a, b   [31:0] in   rs / rt operands
//   hilo   [63:0] in   current {hi, lo}
//   result [63:0] out  value to be committed to {hi, lo}
// Division results are {remainder, quotient}. A zero divisor returns hilo so the
// commit leaves HI/LO unchanged. Optional macro MD_MADD_EN enables op 7 (madd).
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo,
  output logic [63:0] result
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] q_s, r_s, q_u, r_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise paths that skip an assignment infer latches.
  always_comb begin
    q_s = '0;
    r_s = '0;
    q_u = '0;
    r_u = '0;
    if (b != '0) begin
      q_u = a / b;
      r_u = a % b;
      // -2^31 / -1 overflows the 32-bit quotient; the architectural result
      // is the dividend with a zero remainder.
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q_s = 32'h8000_0000;
        r_s = '0;
      end else begin
        q_s = $signed(a) / $signed(b);
        r_s = $signed(a) % $signed(b);
      end
    end
  end

  always_comb begin
    result = hilo;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = (b == '0) ? hilo : {r_s, q_s};
      MD_DIVU:  result = (b == '0) ? hilo : {r_u, q_u};
`ifdef MD_MADD_EN
      MD_MADD:  result = hilo + prod_s;
`endif
      default:  result = hilo;
    endcase
  end

endmodule

// File: rtl/md_hilo_unit.sv
// md_hilo_unit -- E-stage multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   md_op     in   [2:0] E-stage op (md_pkg encoding)
//   md_a/b    in   [31:0] forwarded rs / rt operands
//   hilo_sel  in   read select, 0 LO / 1 HI
//   md_use_D  in   D-stage instruction is an MD-class op
//   busy      out  multi-cycle operation in progress
//   hilo_out  out  [31:0] selected committed HI or LO
//   stall_md  out  stall request to the D stage
//   hi, lo    out  [31:0] committed registers (trace)
// The result is computed and latched when an op starts; it is committed to
// HI/LO on the edge where the busy counter steps 1 -> 0. HI/LO cannot change
// while busy, so a madd accumulating into the start-time {hi, lo} is identical
// to accumulating into the commit-time value.
// Optional macro MD_MADD_EN: md_op 7 = signed madd with MULT_CYCLES latency.
module md_hilo_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        hilo_sel,
  input  logic        md_use_D,
  output logic        busy,
  output logic [31:0] hilo_out,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [63:0]      pend_q, pend_d;
  logic [63:0]      arith_result;
  md_state_e        state;
  logic             start_now;

  md_arith u_arith (
    .op     (md_op),
    .a      (md_a),
    .b      (md_b),
    .hilo   ({hi_q, lo_q}),
    .result (arith_result)
  );

  // The counter itself is the state: non-zero means an operation is running.
  assign state     = (cnt_q != '0) ? MD_RUN : MD_IDLE;
  assign start_now = md_is_start(md_op) && (state == MD_IDLE);

  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    pend_d = pend_q;
    case (state)
      MD_IDLE: begin
        if (start_now) begin
          pend_d = arith_result;
          cnt_d  = md_is_div(md_op) ? DIV_LOAD : MULT_LOAD;
        end else if (md_op == MD_MTHI) begin
          hi_d = md_a;
        end else if (md_op == MD_MTLO) begin
          lo_d = md_a;
        end
      end
      MD_RUN: begin
        // Any md_op arriving here is ignored, including on the commit edge.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          {hi_d, lo_d} = pend_q;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
    end
  end

  assign busy     = (state == MD_RUN);
  assign stall_md = md_use_D && (busy || start_now);
  assign hilo_out = (hilo_sel == HILO_SEL_HI) ? hi_q : lo_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
